simon_datapath: RTL and testbench

Datapath partner of the Simon controller FSM. It holds the pattern memory, the sequence-length (count) and playback-position (index) registers, and the latched difficulty level. It consumes the controller's strobes (count_cnt/clr, index_cnt/clr, w_en, disp_mem, load_level) and returns the three status flags the controller branches on (pattern_valid, index_lt_count, pattern_eq_mem). It also drives the pattern LEDs.

---
 rtl/simon_datapath.sv | 83 ++++++++
 tb/tb_simon_datapath.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_datapath.sv
// Simon datapath: pattern memory, count/index registers and latched level.
// Exposes the status flags the controller branches on and drives the pattern LEDs.
module simon_datapath #(
   parameter int WIDTH     = 4,
   parameter int ADDR_BITS = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             level_sw,
   input  logic [WIDTH-1:0] pattern_sw,
   input  logic             count_cnt,
   input  logic             count_clr,
   input  logic             index_cnt,
   input  logic             index_clr,
   input  logic             w_en,
   input  logic             disp_mem,
   input  logic             load_level,
   output logic             pattern_valid,
   output logic             index_lt_count,
   output logic             pattern_eq_mem,
   output logic [WIDTH-1:0] pattern_leds,
   output logic             level
);

   localparam int                   DEPTH    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] MAX_ADDR = {ADDR_BITS{1'b1}};
   localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_BITS-1:0] count_q, count_d;
   logic [ADDR_BITS-1:0] index_q, index_d;
   logic                 level_q, level_d;
   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [WIDTH-1:0]     rd_data;
   logic                 sw_onehot;

   always_comb begin
      count_d = count_q;
      index_d = index_q;
      level_d = level_q;
      // clear beats increment; both counters stick at the top address
      if (count_clr) begin
         count_d = '0;
      end else if (count_cnt && (count_q != MAX_ADDR)) begin
         count_d = count_q + 1'b1;
      end
      if (index_clr) begin
         index_d = '0;
      end else if (index_cnt && (index_q != MAX_ADDR)) begin
         index_d = index_q + 1'b1;
      end
      if (load_level) begin
         level_d = level_sw;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
         index_q <= '0;
      end else begin
         count_q <= count_d;
         index_q <= index_d;
      end
   end

   // Level and memory ignore reset: the controller loads level while holding reset.
   always_ff @(posedge clk) begin
      level_q <= level_d;
      if (w_en) begin
         mem_q[count_q] <= pattern_sw;
      end
   end

   assign rd_data   = mem_q[index_q];
   assign sw_onehot = (pattern_sw != '0) && ((pattern_sw & (pattern_sw - ONE_W)) == '0);

   assign pattern_valid  = level_q ? 1'b1 : sw_onehot;
   assign index_lt_count = (index_q < count_q);
   assign pattern_eq_mem = (pattern_sw == rd_data);
   assign pattern_leds   = disp_mem ? rd_data : pattern_sw;
   assign level          = level_q;

endmodule

// File: tb/tb_simon_datapath.sv
// Self-checking bench for simon_datapath: expectations queued with each stimulus
// step and drained against the DUT outputs on the falling edge.
module tb_simon_datapath;

   localparam int WIDTH     = 4;
   localparam int ADDR_BITS = 6;

   localparam int SEL_VALID = 0;
   localparam int SEL_LT    = 1;
   localparam int SEL_EQ    = 2;
   localparam int SEL_LEDS  = 3;
   localparam int SEL_LEVEL = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             level_sw;
   logic [WIDTH-1:0] pattern_sw;
   logic             count_cnt, count_clr, index_cnt, index_clr;
   logic             w_en, disp_mem, load_level;
   logic             pattern_valid, index_lt_count, pattern_eq_mem, level;
   logic [WIDTH-1:0] pattern_leds;

   typedef struct {
      string      tag;
      int         sel;
      logic [3:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   simon_datapath #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) dut (
      .clk            (clk),
      .rst            (rst),
      .level_sw       (level_sw),
      .pattern_sw     (pattern_sw),
      .count_cnt      (count_cnt),
      .count_clr      (count_clr),
      .index_cnt      (index_cnt),
      .index_clr      (index_clr),
      .w_en           (w_en),
      .disp_mem       (disp_mem),
      .load_level     (load_level),
      .pattern_valid  (pattern_valid),
      .index_lt_count (index_lt_count),
      .pattern_eq_mem (pattern_eq_mem),
      .pattern_leds   (pattern_leds),
      .level          (level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b, want %b", tag, obs, exp);
      end else begin
         $display("[TB] ok   %s: %b", tag, obs);
      end
   endtask

   task automatic sb_push(input string tag, input int sel, input logic [3:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   // Outputs are sampled on the falling edge, away from the active edge.
   task automatic sb_drain();
      exp_t       e;
      logic [3:0] obs;
      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            SEL_VALID: obs = {3'b000, pattern_valid};
            SEL_LT:    obs = {3'b000, index_lt_count};
            SEL_EQ:    obs = {3'b000, pattern_eq_mem};
            SEL_LEDS:  obs = pattern_leds;
            default:   obs = {3'b000, level};
         endcase
         check_val(e.tag, obs, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      count_cnt  = 1'b0;
      count_clr  = 1'b0;
      index_cnt  = 1'b0;
      index_clr  = 1'b0;
      w_en       = 1'b0;
      load_level = 1'b0;
   endtask

   initial begin
      logic [3:0] v;
      rst        = 1'b0;
      level_sw   = 1'b1;
      load_level = 1'b1;
      pattern_sw = 4'b0000;
      count_cnt  = 1'b0;
      count_clr  = 1'b0;
      index_cnt  = 1'b0;
      index_clr  = 1'b0;
      w_en       = 1'b0;
      disp_mem   = 1'b0;

      // reset with level loaded during reset
      tick();
      sb_push("rst_lt", SEL_LT, 4'd0);
      sb_push("rst_level", SEL_LEVEL, 4'd1);
      sb_drain();
      rst = 1'b1;
      level_sw = 1'b0;
      tick();
      sb_push("rel_lt", SEL_LT, 4'd0);
      sb_push("level_hold", SEL_LEVEL, 4'd1);
      sb_drain();

      // validity in hard mode, then easy mode, all 16 patterns
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         pattern_sw = v;
         sb_push($sformatf("valid_hard_%0d", i), SEL_VALID, 4'd1);
         sb_drain();
      end
      level_sw = 1'b0;
      load_level = 1'b1;
      tick();
      sb_push("level_easy", SEL_LEVEL, 4'd0);
      sb_drain();
      for (int i = 0; i < 16; i++) begin
         v = 4'(i);
         pattern_sw = v;
         sb_push($sformatf("valid_easy_%0d", i), SEL_VALID,
                 ($countones(v) == 1) ? 4'd1 : 4'd0);
         sb_drain();
      end

      // write / playback
      pattern_sw = 4'b0010; w_en = 1'b1; tick();
      count_cnt = 1'b1; tick();
      sb_push("cnt1_lt", SEL_LT, 4'd1);
      sb_drain();
      pattern_sw = 4'b1000; w_en = 1'b1; tick();
      index_clr = 1'b1; tick();
      disp_mem = 1'b1;
      sb_push("play0_leds", SEL_LEDS, 4'b0010);
      sb_push("play0_lt", SEL_LT, 4'd1);
      sb_push("play0_eq", SEL_EQ, 4'd0);
      sb_drain();
      index_cnt = 1'b1; tick();
      sb_push("play1_leds", SEL_LEDS, 4'b1000);
      sb_push("play1_lt", SEL_LT, 4'd0);
      sb_push("cmp_eq1", SEL_EQ, 4'd1);
      sb_drain();
      pattern_sw = 4'b0001;
      sb_push("cmp_eq0", SEL_EQ, 4'd0);
      sb_push("cmp_leds_mem", SEL_LEDS, 4'b1000);
      sb_drain();
      disp_mem = 1'b0;
      sb_push("cmp_leds_sw", SEL_LEDS, 4'b0001);
      sb_drain();

      // write with count_cnt on same edge uses old count (index=1, count=1)
      pattern_sw = 4'b0100; w_en = 1'b1; count_cnt = 1'b1; tick();
      disp_mem = 1'b1;
      sb_push("wcnt_leds", SEL_LEDS, 4'b0100);
      sb_push("wcnt_lt", SEL_LT, 4'd1);
      sb_drain();

      // read during write at index=count=2
      index_cnt = 1'b1; tick();
      pattern_sw = 4'b0001; w_en = 1'b1; tick();
      pattern_sw = 4'b0100; w_en = 1'b1;
      sb_push("rdw_eq_before", SEL_EQ, 4'd0);
      sb_push("rdw_leds_before", SEL_LEDS, 4'b0001);
      sb_drain();
      tick();
      sb_push("rdw_eq_after", SEL_EQ, 4'd1);
      sb_push("rdw_leds_after", SEL_LEDS, 4'b0100);
      sb_drain();

      // clr beats cnt (count 2 -> 0, index stays 2)
      count_clr = 1'b1; count_cnt = 1'b1; tick();
      sb_push("cclr_prio_lt", SEL_LT, 4'd0);
      sb_drain();
      count_cnt = 1'b1; tick();
      index_clr = 1'b1; index_cnt = 1'b1; tick();
      sb_push("iclr_prio_lt", SEL_LT, 4'd1);
      sb_drain();

      // count saturation: 1 + 70 pulses must stick at 63
      for (int i = 0; i < 70; i++) begin
         count_cnt = 1'b1; tick();
      end
      for (int i = 0; i < 62; i++) begin
         index_cnt = 1'b1; tick();
      end
      sb_push("sat_idx62_lt", SEL_LT, 4'd1);
      sb_drain();
      index_cnt = 1'b1; tick();
      sb_push("sat_idx63_lt", SEL_LT, 4'd0);
      sb_drain();
      for (int i = 0; i < 10; i++) begin
         index_cnt = 1'b1; tick();
      end
      sb_push("sat_idx_hold_lt", SEL_LT, 4'd0);
      sb_drain();
      pattern_sw = 4'b1001; w_en = 1'b1; tick();
      sb_push("top_addr_leds", SEL_LEDS, 4'b1001);
      sb_push("top_addr_eq", SEL_EQ, 4'd1);
      sb_drain();

      // reset mid-playback keeps mem and level
      rst = 1'b0; tick();
      rst = 1'b1;
      sb_push("midrst_lt", SEL_LT, 4'd0);
      sb_push("midrst_level", SEL_LEVEL, 4'd0);
      sb_push("midrst_mem0", SEL_LEDS, 4'b0010);
      sb_drain();
      count_cnt = 1'b1; tick();
      sb_push("midrst_cnt_lt", SEL_LT, 4'd1);
      sb_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
